// File: rtl/mem_access_ctrl_if.sv
// Host-side request / write-data / response channels of the memory access
// controller, bundled with the pins that drive the DFF memory array.
interface mem_access_ctrl_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [2:0]    req_len;

    logic          wdata_valid;
    logic          wdata_ready;
    logic [DW-1:0] wdata;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_last;
    logic          rsp_err;

    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    // Host plus memory array side
    modport master (
        output req_valid, req_we, req_addr, req_len,
        output wdata_valid, wdata,
        output rsp_ready,
        output mem_dout,
        input  req_ready, wdata_ready,
        input  rsp_valid, rsp_data, rsp_last, rsp_err,
        input  mem_cs, mem_we, mem_addr, mem_din
    );

    // Controller side
    modport slave (
        input  req_valid, req_we, req_addr, req_len,
        input  wdata_valid, wdata,
        input  rsp_ready,
        input  mem_dout,
        output req_ready, wdata_ready,
        output rsp_valid, rsp_data, rsp_last, rsp_err,
        output mem_cs, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Burst front-end for the gated-clock DFF memory array. Sequences cs/we so
// the write strobe is always surrounded by a setup and a recovery cycle with
// address and data held, and returns read data / write acks on a registered
// response channel. Bursts wrap inside the implemented DEPTH words.
module mem_access_ctrl #(
    parameter int AW    = 12,
    parameter int DW    = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_ctrl_if.slave bus
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [3:0] {
        IDLE, RD, RSP, WDATA, WSETUP, WSTROBE, WRECOV, WRSP, RERR
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    beat_q, beat_d;
    logic [2:0]    len_q, len_d;
    logic [AW-1:0] base_q, base_d;
    logic          err_q, err_d;

    logic          req_ready_q, req_ready_d;
    logic          wdata_ready_q, wdata_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_last_q, rsp_last_d;
    logic          rsp_err_q, rsp_err_d;
    logic          mem_cs_q, mem_cs_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_din_q, mem_din_d;

    logic reqFire;
    logic wdataFire;
    logic rspFire;
    logic lastBeat;
    logic reqOutOfRange;

    assign reqFire       = (state_q == IDLE) && req_ready_q && bus.req_valid;
    assign wdataFire     = (state_q == WDATA) && wdata_ready_q && bus.wdata_valid;
    assign rspFire       = rsp_valid_q && bus.rsp_ready;
    assign lastBeat      = (beat_q == len_q);
    assign reqOutOfRange = (bus.req_addr >= AW'(DEPTH));

    // Only the low index bits advance; upper address bits stay as the base had them
    function automatic logic [AW-1:0] beatAddr(input logic [AW-1:0] base,
                                               input logic [2:0]    beat);
        logic [AW-1:0] addr;
        addr          = base;
        addr[IW-1:0]  = base[IW-1:0] + IW'(beat);
        return addr;
    endfunction

    // Next state plus the registered output values that belong to that state
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        len_d      = len_q;
        base_d     = base_q;
        err_d      = err_q;
        rsp_data_d = rsp_data_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;

        case (state_q)
            IDLE: begin
                if (reqFire) begin
                    base_d = bus.req_addr;
                    len_d  = bus.req_len;
                    err_d  = reqOutOfRange;
                    beat_d = '0;
                    if (bus.req_we) begin
                        state_d = WDATA;
                    end else if (reqOutOfRange) begin
                        state_d = RERR;
                    end else begin
                        state_d    = RD;
                        mem_addr_d = beatAddr(bus.req_addr, 3'd0);
                    end
                end
            end
            RD: begin
                rsp_data_d = bus.mem_dout;
                state_d    = RSP;
            end
            RSP: begin
                if (rspFire) begin
                    if (lastBeat) begin
                        state_d = IDLE;
                    end else begin
                        beat_d     = beat_q + 3'd1;
                        mem_addr_d = beatAddr(base_q, beat_q + 3'd1);
                        state_d    = RD;
                    end
                end
            end
            WDATA: begin
                if (wdataFire) begin
                    if (err_q) begin
                        if (lastBeat) begin
                            state_d = WRSP;
                        end else begin
                            beat_d = beat_q + 3'd1;
                        end
                    end else begin
                        mem_din_d  = bus.wdata;
                        mem_addr_d = beatAddr(base_q, beat_q);
                        state_d    = WSETUP;
                    end
                end
            end
            WSETUP:  state_d = WSTROBE;
            WSTROBE: state_d = WRECOV;
            WRECOV: begin
                if (lastBeat) begin
                    state_d = WRSP;
                end else begin
                    beat_d  = beat_q + 3'd1;
                    state_d = WDATA;
                end
            end
            WRSP, RERR: begin
                if (rspFire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d   = (state_d == IDLE);
        wdata_ready_d = (state_d == WDATA);
        mem_cs_d      = (state_d inside {RD, WSETUP, WSTROBE, WRECOV});
        mem_we_d      = (state_d == WSTROBE);
        rsp_valid_d   = (state_d inside {RSP, WRSP, RERR});
        rsp_last_d    = 1'b0;
        rsp_err_d     = 1'b0;
        case (state_d)
            RSP:  rsp_last_d = (beat_d == len_d);
            WRSP: begin
                rsp_last_d = 1'b1;
                rsp_err_d  = err_d;
                rsp_data_d = '0;
            end
            RERR: begin
                rsp_last_d = 1'b1;
                rsp_err_d  = 1'b1;
                rsp_data_d = '0;
            end
            default: ;
        endcase
    end

    // State, burst context and every output are registered; reset aborts any burst
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            len_q         <= '0;
            base_q        <= '0;
            err_q         <= 1'b0;
            req_ready_q   <= 1'b0;
            wdata_ready_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_last_q    <= 1'b0;
            rsp_err_q     <= 1'b0;
            mem_cs_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            len_q         <= len_d;
            base_q        <= base_d;
            err_q         <= err_d;
            req_ready_q   <= req_ready_d;
            wdata_ready_q <= wdata_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_last_q    <= rsp_last_d;
            rsp_err_q     <= rsp_err_d;
            mem_cs_q      <= mem_cs_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.wdata_ready = wdata_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_last    = rsp_last_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.mem_cs      = mem_cs_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_din     = mem_din_q;
endmodule
